// File: rtl/match_flow_ctrl.sv
// match_flow_ctrl: game-flow sequencer for the volleyball physics engine.
// Generates the frame tick, gates the physics enable by match state, keeps
// score from physics point-end events and declares the match winner.
module match_flow_ctrl #(
    parameter int unsigned FRAME_DIV    = 416667,
    parameter int unsigned SERVE_FRAMES = 90,
    parameter int unsigned POINT_FRAMES = 60,
    parameter int unsigned WIN_SCORE    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       phy_game_over,
    input  logic [1:0] phy_winner,
    output logic       phy_en,
    output logic       phy_srst_n,
    output logic       frame_tick,
    output logic [2:0] state,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [7:0] frames_left,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_POINT = 3'd4,
        ST_OVER  = 3'd5
    } state_t;

    localparam logic [19:0] DIV_LAST   = 20'(FRAME_DIV - 1);
    localparam logic [7:0]  SERVE_INIT = 8'(SERVE_FRAMES);
    localparam logic [7:0]  POINT_INIT = 8'(POINT_FRAMES);
    localparam logic [3:0]  WIN_PTS    = 4'(WIN_SCORE);

    // Scores stop at the top of their 4-bit range instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    logic [19:0] div_q, div_d;
    logic        div_wrap;
    logic        tick_q, en_q;
    logic        start_prev_q, pause_prev_q, go_prev_q;
    logic        start_rise, pause_rise, go_rise;
    state_t      state_q, state_d;
    logic [3:0]  p1_q, p1_d, p2_q, p2_d;
    logic [3:0]  p1_inc, p2_inc;
    logic [7:0]  fl_q, fl_d;
    logic [1:0]  mw_q, mw_d;
    logic        srst_n_q, srst_n_d;

    // Free-running frame divider next-count.
    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? 20'd0 : div_q + 20'd1;
    end

    // Divider counter plus the registered tick and its PLAY-gated twin, so both pulse together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= 20'd0;
            tick_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= div_wrap;
            en_q   <= div_wrap && (state_q == ST_PLAY);
        end
    end

    // Previous-cycle copies of the inputs for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            go_prev_q    <= 1'b0;
        end else begin
            start_prev_q <= start_btn;
            pause_prev_q <= pause_btn;
            go_prev_q    <= phy_game_over;
        end
    end

    assign start_rise = start_btn && !start_prev_q;
    assign pause_rise = pause_btn && !pause_prev_q;
    assign go_rise    = phy_game_over && !go_prev_q;
    assign p1_inc     = sat_inc(p1_q);
    assign p2_inc     = sat_inc(p2_q);

    // Match FSM next-state: countdowns, scoring and winner detection.
    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        fl_d     = fl_q;
        mw_d     = mw_q;
        srst_n_d = 1'b1;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    state_d  = ST_SERVE;
                    fl_d     = SERVE_INIT;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    mw_d     = 2'd0;
                    srst_n_d = 1'b0;
                end
            end
            ST_SERVE: begin
                if (tick_q) begin
                    if (fl_q <= 8'd1) begin
                        fl_d    = 8'd0;
                        state_d = ST_PLAY;
                    end else begin
                        fl_d = fl_q - 8'd1;
                    end
                end
            end
            ST_POINT: begin
                if (tick_q) begin
                    if (fl_q <= 8'd1) begin
                        fl_d    = SERVE_INIT;
                        state_d = ST_SERVE;
                    end else begin
                        fl_d = fl_q - 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                // A point end outranks a pause request arriving on the same clock.
                if (go_rise) begin
                    state_d = ST_POINT;
                    fl_d    = POINT_INIT;
                    if (phy_winner == 2'd1) begin
                        p1_d = p1_inc;
                        if (p1_inc == WIN_PTS) begin
                            state_d = ST_OVER;
                            fl_d    = 8'd0;
                            mw_d    = 2'd1;
                        end
                    end else if (phy_winner == 2'd2) begin
                        p2_d = p2_inc;
                        if (p2_inc == WIN_PTS) begin
                            state_d = ST_OVER;
                            fl_d    = 8'd0;
                            mw_d    = 2'd2;
                        end
                    end
                end else if (pause_rise) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_rise) begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fl_d    = 8'd0;
            end
        endcase
    end

    // Match FSM state and score registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            p1_q     <= 4'd0;
            p2_q     <= 4'd0;
            fl_q     <= 8'd0;
            mw_q     <= 2'd0;
            srst_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            fl_q     <= fl_d;
            mw_q     <= mw_d;
            srst_n_q <= srst_n_d;
        end
    end

    assign phy_en       = en_q;
    assign phy_srst_n   = srst_n_q;
    assign frame_tick   = tick_q;
    assign state        = state_q;
    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign frames_left  = fl_q;
    assign match_winner = mw_q;

endmodule

// File: tb/tb_match_flow_ctrl.sv
// Bench for match_flow_ctrl: directed match walk-through with literal checks,
// then randomized inputs, all compared every cycle against a behavioural model.
module tb_match_flow_ctrl;

    localparam int FD  = 4;
    localparam int SF  = 3;
    localparam int PF  = 2;
    localparam int WIN = 2;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSE = 3, S_POINT = 4, S_OVER = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_btn = 1'b0;
    logic       pause_btn = 1'b0;
    logic       phy_game_over = 1'b0;
    logic [1:0] phy_winner = 2'd0;
    logic       phy_en, phy_srst_n, frame_tick;
    logic [2:0] state;
    logic [3:0] p1_score, p2_score;
    logic [7:0] frames_left;
    logic [1:0] match_winner;

    match_flow_ctrl #(
        .FRAME_DIV(FD), .SERVE_FRAMES(SF), .POINT_FRAMES(PF), .WIN_SCORE(WIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .pause_btn(pause_btn),
        .phy_game_over(phy_game_over), .phy_winner(phy_winner),
        .phy_en(phy_en), .phy_srst_n(phy_srst_n), .frame_tick(frame_tick),
        .state(state), .p1_score(p1_score), .p2_score(p2_score),
        .frames_left(frames_left), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: time measured in clock edges since reset release,
    // match rules applied on each edge from the inputs seen at that edge.
    int m_cyc, m_state, m_p1, m_p2, m_fl, m_mw;
    bit m_tick, m_en, m_srst;
    bit pv_s, pv_p, pv_g;

    task automatic model_edge();
        bit s_r, p_r, g_r, was_tick;
        int old;
        if (!rst_n) begin
            m_cyc = 0; m_state = S_IDLE; m_p1 = 0; m_p2 = 0; m_fl = 0; m_mw = 0;
            m_tick = 0; m_en = 0; m_srst = 1; pv_s = 0; pv_p = 0; pv_g = 0;
            return;
        end
        s_r = start_btn && !pv_s;
        p_r = pause_btn && !pv_p;
        g_r = phy_game_over && !pv_g;
        pv_s = start_btn; pv_p = pause_btn; pv_g = phy_game_over;
        was_tick = m_tick;
        old = m_state;
        m_cyc++;
        m_tick = (m_cyc % FD) == 0;
        m_en = m_tick && (old == S_PLAY);
        m_srst = 1;
        if ((old == S_IDLE || old == S_OVER) && s_r) begin
            m_state = S_SERVE; m_fl = SF; m_p1 = 0; m_p2 = 0; m_mw = 0; m_srst = 0;
        end else if ((old == S_SERVE || old == S_POINT) && was_tick) begin
            m_fl = m_fl - 1;
            if (m_fl == 0) begin
                m_state = (old == S_SERVE) ? S_PLAY : S_SERVE;
                m_fl = (old == S_SERVE) ? 0 : SF;
            end
        end else if (old == S_PLAY && g_r) begin
            m_state = S_POINT; m_fl = PF;
            if (phy_winner == 2'd1) m_p1 = (m_p1 < 15) ? m_p1 + 1 : 15;
            if (phy_winner == 2'd2) m_p2 = (m_p2 < 15) ? m_p2 + 1 : 15;
            if (phy_winner == 2'd1 && m_p1 == WIN) begin m_state = S_OVER; m_fl = 0; m_mw = 1; end
            if (phy_winner == 2'd2 && m_p2 == WIN) begin m_state = S_OVER; m_fl = 0; m_mw = 2; end
        end else if ((old == S_PLAY || old == S_PAUSE) && p_r) begin
            m_state = (old == S_PLAY) ? S_PAUSE : S_PLAY;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_edge();

    task automatic cmp_all(input string tag);
        chk({tag, ".state"}, 32'(state), 32'(m_state));
        chk({tag, ".p1_score"}, 32'(p1_score), 32'(m_p1));
        chk({tag, ".p2_score"}, 32'(p2_score), 32'(m_p2));
        chk({tag, ".frames_left"}, 32'(frames_left), 32'(m_fl));
        chk({tag, ".match_winner"}, 32'(match_winner), 32'(m_mw));
        chk({tag, ".frame_tick"}, 32'(frame_tick), 32'(m_tick));
        chk({tag, ".phy_en"}, 32'(phy_en), 32'(m_en));
        chk({tag, ".phy_srst_n"}, 32'(phy_srst_n), 32'(m_srst));
    endtask

    always @(negedge clk) if (chk_on) cmp_all("cyc");

    task automatic tick_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int budget);
        int k;
        k = 0;
        while (m_state != s && k < budget) begin
            tick_cyc();
            k++;
        end
        if (m_state != s) chk("wait_state_timeout", 32'(m_state), 32'(s));
    endtask

    // Emulates the physics block clearing game_over on its first enable.
    task automatic wait_en_drop(input int budget);
        int k;
        k = 0;
        while (!m_en && k < budget) begin
            tick_cyc();
            k++;
        end
        if (!m_en) chk("wait_en_timeout", 32'(m_en), 32'd1);
        phy_game_over = 1'b0;
        tick_cyc();
        tick_cyc();
    endtask

    int cnt, cnt2;

    initial begin
        repeat (3) tick_cyc();
        rst_n = 1'b1;
        chk_on = 1'b1;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.frame_tick", 32'(frame_tick), 32'd0);
        chk("rst.phy_srst_n", 32'(phy_srst_n), 32'd1);
        chk("rst.frames_left", 32'(frames_left), 32'd0);

        // Idle: one tick every FD clocks, no enable.
        cnt = 0; cnt2 = 0;
        repeat (20) begin
            tick_cyc();
            cnt += int'(frame_tick);
            cnt2 += int'(phy_en);
        end
        chk("idle.tick_count", 32'(cnt), 32'd5);
        chk("idle.en_count", 32'(cnt2), 32'd0);

        // Start a match.
        start_btn = 1'b1; tick_cyc(); start_btn = 1'b0;
        chk("start.state", 32'(state), 32'd1);
        chk("start.srst_n", 32'(phy_srst_n), 32'd0);
        chk("start.frames_left", 32'(frames_left), 32'd3);
        tick_cyc();
        chk("start.srst_n_release", 32'(phy_srst_n), 32'd1);

        wait_state(S_PLAY, 40);
        cnt = 0;
        repeat (8) begin tick_cyc(); cnt += int'(phy_en); end
        chk("play.en_count", 32'(cnt), 32'd2);

        // P1 point with game_over held through POINT and SERVE.
        phy_winner = 2'd1; phy_game_over = 1'b1; tick_cyc();
        chk("p1pt.p1_score", 32'(p1_score), 32'd1);
        chk("p1pt.state", 32'(state), 32'd4);
        wait_state(S_SERVE, 40);
        wait_state(S_PLAY, 40);
        wait_en_drop(20);
        chk("p1pt.held_no_rescore", 32'(p1_score), 32'd1);

        // P2 scores twice and wins.
        for (int k = 0; k < 2; k++) begin
            wait_state(S_PLAY, 60);
            phy_winner = 2'd2; phy_game_over = 1'b1; tick_cyc();
            if (k == 0) begin
                chk("p2a.state", 32'(state), 32'd4);
                wait_state(S_PLAY, 60);
                wait_en_drop(20);
            end else begin
                chk("over.state", 32'(state), 32'd5);
                chk("over.p2_score", 32'(p2_score), 32'd2);
                chk("over.match_winner", 32'(match_winner), 32'd2);
                tick_cyc();
                phy_game_over = 1'b0;
            end
        end
        cnt = 0;
        repeat (12) begin tick_cyc(); cnt += int'(phy_en); end
        chk("over.en_count", 32'(cnt), 32'd0);

        // Restart from OVER.
        start_btn = 1'b1; tick_cyc(); start_btn = 1'b0;
        chk("restart.state", 32'(state), 32'd1);
        chk("restart.p1", 32'(p1_score), 32'd0);
        chk("restart.p2", 32'(p2_score), 32'd0);
        chk("restart.mw", 32'(match_winner), 32'd0);
        chk("restart.srst_n", 32'(phy_srst_n), 32'd0);

        // Pause for 10 frames, then resume.
        wait_state(S_PLAY, 60);
        pause_btn = 1'b1; tick_cyc(); pause_btn = 1'b0;
        chk("pause.state", 32'(state), 32'd3);
        cnt = 0; cnt2 = 0;
        repeat (40) begin
            tick_cyc();
            cnt += int'(phy_en);
            cnt2 += int'(frame_tick);
        end
        chk("pause.en_count", 32'(cnt), 32'd0);
        chk("pause.tick_count", 32'(cnt2), 32'd10);
        pause_btn = 1'b1; tick_cyc(); pause_btn = 1'b0;
        chk("resume.state", 32'(state), 32'd2);
        tick_cyc();

        // Same-clock pause and point end: the point wins.
        pause_btn = 1'b1; phy_winner = 2'd1; phy_game_over = 1'b1; tick_cyc();
        pause_btn = 1'b0;
        chk("simul.state", 32'(state), 32'd4);
        chk("simul.p1", 32'(p1_score), 32'd1);
        wait_state(S_PLAY, 60);
        wait_en_drop(20);

        // Invalid winner code: no score, still a point end.
        phy_winner = 2'd3; phy_game_over = 1'b1; tick_cyc();
        chk("inval.state", 32'(state), 32'd4);
        chk("inval.p1", 32'(p1_score), 32'd1);
        chk("inval.p2", 32'(p2_score), 32'd0);

        // Asynchronous reset in the middle of SERVE.
        wait_state(S_SERVE, 40);
        rst_n = 1'b0;
        #1;
        chk("arst.state", 32'(state), 32'd0);
        chk("arst.p1", 32'(p1_score), 32'd0);
        chk("arst.frames_left", 32'(frames_left), 32'd0);
        chk("arst.srst_n", 32'(phy_srst_n), 32'd1);
        chk("arst.tick", 32'(frame_tick), 32'd0);
        phy_game_over = 1'b0;
        tick_cyc(); tick_cyc();
        rst_n = 1'b1;

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            tick_cyc();
            if ($urandom_range(0, 19) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 24) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 14) == 0) phy_game_over = ~phy_game_over;
            if ($urandom_range(0, 9) == 0) phy_winner = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                #2;
                cmp_all("rnd_arst");
                tick_cyc();
                rst_n = 1'b1;
            end
        end
        tick_cyc();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
